// File: rtl/gp_dispatch_if.sv
// Command-stream and engine-bus signals of the graphics command dispatcher.
// The slave modport is the dispatcher; master is the fetch FIFO / engine side.
interface gp_dispatch_if #(
    parameter int unsigned NUM_ENGINES = 4
);
    logic                   cmd_valid;
    logic [31:0]            cmd_data;
    logic                   cmd_ready;
    logic [NUM_ENGINES-1:0] eng_ready;
    logic [NUM_ENGINES-1:0] eng_valid;
    logic [31:0]            eng_data;
    logic [3:0]             eng_idx;
    logic                   eng_last;

    modport master (
        output cmd_valid, cmd_data, eng_ready,
        input  cmd_ready, eng_valid, eng_data, eng_idx, eng_last
    );

    modport slave (
        input  cmd_valid, cmd_data, eng_ready,
        output cmd_ready, eng_valid, eng_data, eng_idx, eng_last
    );
endinterface

// File: rtl/gp_dispatch.sv
// Parametrised graphics command dispatcher: routes header + argument words to
// one of NUM_ENGINES engines, drains on STOP and holds done until acknowledged.
module gp_dispatch #(
    parameter int unsigned                 NUM_ENGINES = 4,
    parameter logic [7:0]                  OPCODE_BASE = 8'h01,
    parameter logic [7:0]                  STOP_OPCODE = 8'h00,
    parameter logic [4*NUM_ENGINES-1:0]    ARG_COUNTS  = 16'h3120
) (
    input  logic        clk,
    input  logic        rst,
    gp_dispatch_if.slave bus,
    input  logic        abort,
    input  logic        frame_ready,
    output logic        done,
    output logic        err_unknown,
    output logic [15:0] cmd_count
);
    typedef enum logic [1:0] {ST_HEADER, ST_ARGS, ST_DRAIN, ST_DONE} state_t;

    state_t                 state, state_n;
    logic [NUM_ENGINES-1:0] tgt_q, tgt_n;
    logic [3:0]             rem_q, rem_n;
    logic [3:0]             idx_q, idx_n;
    logic [15:0]            cnt_n;
    logic                   err_n;

    logic [7:0]             op;
    logic [7:0]             hdr_off;
    logic [NUM_ENGINES-1:0] hdr_oh;
    logic [3:0]             hdr_args;
    logic                   rdy;
    logic                   hs;
    logic [NUM_ENGINES-1:0] strobe;
    logic                   last;

    assign op            = bus.cmd_data[31:24];
    assign hdr_off       = op - OPCODE_BASE;
    assign bus.eng_data  = bus.cmd_data;

    // Opcode decode into a one-hot engine select, avoiding variable indexing.
    always_comb begin
        hdr_oh   = '0;
        hdr_args = '0;
        for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
            if (hdr_off == 8'(i)) begin
                hdr_oh[i] = 1'b1;
                hdr_args  = ARG_COUNTS[4*i +: 4];
            end
        end
    end

    // Ready depends only on state, decoded opcode and eng_ready, never on valid.
    always_comb begin
        rdy = 1'b0;
        case (state)
            ST_HEADER: begin
                if (op == STOP_OPCODE)
                    rdy = 1'b1;
                else if (|hdr_oh)
                    rdy = |(bus.eng_ready & hdr_oh);
                else
                    rdy = 1'b1;
            end
            ST_ARGS: rdy = |(bus.eng_ready & tgt_q);
            default: rdy = 1'b0;
        endcase
    end

    assign bus.cmd_ready = rdy & ~abort & ~rst;
    assign hs            = bus.cmd_valid & rdy & ~abort & ~rst;

    always_comb begin
        state_n = state;
        tgt_n   = tgt_q;
        rem_n   = rem_q;
        idx_n   = idx_q;
        cnt_n   = cmd_count;
        err_n   = err_unknown;
        strobe  = '0;
        last    = 1'b0;
        case (state)
            ST_HEADER: begin
                if (op == STOP_OPCODE) begin
                    if (hs)
                        state_n = ST_DRAIN;
                end else if (|hdr_oh) begin
                    if (hs) begin
                        strobe = hdr_oh;
                        tgt_n  = hdr_oh;
                        if (hdr_args == 4'd0) begin
                            last  = 1'b1;
                            cnt_n = cmd_count + 16'd1;
                        end else begin
                            rem_n   = hdr_args;
                            idx_n   = 4'd1;
                            state_n = ST_ARGS;
                        end
                    end
                end else if (hs) begin
                    err_n = 1'b1;
                end
            end
            ST_ARGS: begin
                if (hs) begin
                    strobe = tgt_q;
                    if (rem_q == 4'd1) begin
                        last    = 1'b1;
                        cnt_n   = cmd_count + 16'd1;
                        rem_n   = '0;
                        idx_n   = '0;
                        state_n = ST_HEADER;
                    end else begin
                        rem_n = rem_q - 4'd1;
                        idx_n = idx_q + 4'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (&bus.eng_ready)
                    state_n = ST_DONE;
            end
            ST_DONE: begin
                if (frame_ready)
                    state_n = ST_HEADER;
            end
            default: state_n = ST_HEADER;
        endcase
        if (abort) begin
            state_n = ST_HEADER;
            rem_n   = '0;
            idx_n   = '0;
        end
    end

    assign bus.eng_valid = strobe;
    assign bus.eng_last  = last;
    assign bus.eng_idx   = (state == ST_ARGS && !abort && !rst) ? idx_q : 4'd0;
    assign done          = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_HEADER;
            tgt_q       <= '0;
            rem_q       <= '0;
            idx_q       <= '0;
            cmd_count   <= '0;
            err_unknown <= 1'b0;
        end else begin
            state       <= state_n;
            tgt_q       <= tgt_n;
            rem_q       <= rem_n;
            idx_q       <= idx_n;
            cmd_count   <= cnt_n;
            err_unknown <= err_n;
        end
    end
endmodule

// File: doc/gp_dispatch.md
Name: gp_dispatch

Overview:
- Parametrised command dispatcher that succeeds the fixed fill/line/circle command processor.
- Consumes the 32-bit graphics command word stream coming out of the command-fetch FIFO.
- Routes each command's header word and its argument words to one of NUM_ENGINES drawing engines over a shared data bus with per-engine valid/ready.
- On STOP, drains all engines and then holds a done flag until the frame is acknowledged.

Parameters:
- NUM_ENGINES, 4, number of engine channels (1..15).
- OPCODE_BASE, 8'h01, opcode of engine 0; engine i uses opcode OPCODE_BASE+i.
- STOP_OPCODE, 8'h00, end-of-list opcode.
- ARG_COUNTS, 16'h3120, packed 4 bits per engine; bits [4i+3:4i] give the number of argument words after the header (0..15). Default: fill 0, line 2, circle 1, engine3 3.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command word available.
- cmd_data  in  32  command word; opcode is [31:24].
- cmd_ready  out  1  word consumed this cycle when cmd_valid&cmd_ready.
- abort  in  1  flush the current command and return to HEADER.
- eng_ready  in  NUM_ENGINES  per-engine ready.
- eng_valid  out  NUM_ENGINES  one-hot word strobe to the target engine.
- eng_data  out  32  equal to cmd_data (combinational pass-through).
- eng_idx  out  4  word index within the command; 0 = header.
- eng_last  out  1  final word of the command (acts as trigger).
- frame_ready  in  1  consumer acknowledges done.
- done  out  1  held high from drain-complete until frame_ready.
- err_unknown  out  1  sticky: an unknown opcode was seen.
- cmd_count  out  16  number of completed commands.

Behaviour:
- Reset values:
  - state = HEADER.
  - eng_valid = 0, eng_idx = 0, eng_last = 0.
  - done = 0, err_unknown = 0, cmd_count = 0.
  - cmd_ready = 0 during the rst cycle.
- Handshake definitions:
  - A handshake occurs when cmd_valid & cmd_ready.
  - eng_valid[t] is asserted only in the cycle of a handshake and only for the target engine t.
  - cmd_ready may depend combinationally on eng_ready; neither eng_valid nor cmd_ready may depend on itself. There is zero-cycle latency from input to engine.
- HEADER state, decoded by opcode op:
  - Valid engine opcode (t = op-OPCODE_BASE < NUM_ENGINES):
    - cmd_ready = eng_ready[t].
    - On handshake: eng_valid[t]=1, eng_idx=0, latch t, set remaining = ARG_COUNTS[t].
    - If ARG_COUNTS[t]==0: eng_last=1, cmd_count++, stay in HEADER. Otherwise go to ARGS.
  - STOP_OPCODE:
    - cmd_ready=1, no eng_valid.
    - Next state DRAIN.
  - Any other opcode:
    - cmd_ready=1, word discarded, err_unknown<=1.
    - Stay in HEADER.
- ARGS state:
  - cmd_ready = eng_ready[t].
  - On handshake: eng_valid[t]=1, eng_idx = word number (1..N), remaining--.
  - When remaining==1 at handshake: eng_last=1, cmd_count++, next state HEADER.
  - Argument words are never opcode-decoded.
- DRAIN state:
  - cmd_ready=0.
  - Wait until all eng_ready bits are 1 (every engine idle), then go to DONE.
- DONE state:
  - done=1, cmd_ready=0.
  - When frame_ready=1: done<=0 next cycle and state goes to HEADER.
  - A frame_ready already high on DONE entry releases after exactly one cycle of done.
  - frame_ready outside DONE is ignored.
- abort:
  - In any state, abort=1 forces cmd_ready=0 and eng_valid=0 that cycle, and next state HEADER.
  - done clears and remaining clears.
  - A partially delivered command is abandoned: the engine sees no eng_last and restarts on its next idx-0 word.
  - err_unknown and cmd_count are preserved.
  - abort takes priority over frame_ready and over a same-cycle handshake.
- Arithmetic:
  - cmd_count wraps 16'hFFFF -> 0.
  - eng_idx is 4 bits, with a maximum of 15.
  - err_unknown clears only on rst.
- Stalls:
  - cmd_valid low in HEADER or ARGS: hold state, no strobes.
  - Engine not ready: hold state; the word stays pending at the input.

Test Plan:
- Fill then STOP: words {0x01FF0000}, {0x00000000}, engines always ready. Required: eng_valid=0001 with idx 0 and last=1; cmd_count=1; DRAIN then done=1; frame_ready pulse gives done=0 and state HEADER.
- Line with stall: header 0x0200FF00, then args 0x00100020 and 0x00300040, with eng_ready[1] low for 3 cycles before the second arg. Required: three eng_valid[1] strobes with idx 0,1,2; cmd_ready low during the stall; last only on idx 2; data passes through unchanged.
- Unknown opcode 0x7A000000 between two circle commands. Required: word consumed with no strobe; err_unknown=1; both circles delivered with idx 0,1; cmd_count=2.
- abort asserted on the cycle of the line's second arg handshake. Required: no eng_valid that cycle; next word 0x03123456 is treated as a header (circle, engine 2); cmd_count unchanged by the aborted line.
- STOP with eng_ready=1011 held for 5 cycles, then 1111. Required: done rises exactly 1 cycle after all-ready; with frame_ready already high, done lasts one cycle.
- Count wrap: 65537 fill commands. Required: cmd_count=1. rst mid-ARGS returns all outputs to reset values on the next cycle.
